// File: rtl/rail_sequencer.sv
// rail_sequencer: ordered power-up / power-down of NUM_RAILS supply rails
// with per-rail power-good timeout, settle dwell and fault latch.
//
// Ports:
//   sysclk      in   sequencer clock
//   reset_INV   in   asynchronous active-low reset
//   enable      in   1 = bring rails up, 0 = bring rails down
//   pg          in   power-good per rail, bit 0 powers up first
//   en          out  registered rail enables
//   all_good    out  high only in ON
//   fault       out  high only in FAULT
//   fault_rail  out  index of the rail that faulted
//   state       out  OFF=0 RAMP=1 SETTLE=2 ON=3 SHUTDOWN=4 FAULT=5
//
// Build option: define RAIL_SEQ_AUTO_RETRY_EN to leave FAULT on its own
// after RETRY_CYCLES while enable stays high.
`timescale 1ns/1ps

module rail_sequencer #(
  parameter int NUM_RAILS      = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int SETTLE_CYCLES  = 1600,
  parameter int RETRY_CYCLES   = 50000
) (
  input  logic                 sysclk,
  input  logic                 reset_INV,
  input  logic                 enable,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] en,
  output logic                 all_good,
  output logic                 fault,
  output logic [3:0]           fault_rail,
  output logic [2:0]           state
);

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_RAMP     = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_ON       = 3'd3;
  localparam logic [2:0] S_SHUTDOWN = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [3:0] LAST_IDX =
    4'(NUM_RAILS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
`ifdef RAIL_SEQ_AUTO_RETRY_EN
  localparam logic [CNT_W-1:0] RTY_LAST =
    CNT_W'(RETRY_CYCLES - 1);
`endif

  // Elaboration-time parameter checks.
  generate
    if (NUM_RAILS < 2 || NUM_RAILS > 16) begin : g_bad_rails
      $error("rail_sequencer: NUM_RAILS must be 2..16");
    end
    if (CNT_W < 2 || CNT_W > 30) begin : g_bad_cnt_w
      $error("rail_sequencer: CNT_W must be 2..30");
    end
    if (TIMEOUT_CYCLES < 1 ||
        SETTLE_CYCLES < 1 ||
        RETRY_CYCLES < 1) begin : g_bad_cycles
      $error("rail_sequencer: cycle counts must be >= 1");
    end
    if (TIMEOUT_CYCLES > (1 << CNT_W) ||
        SETTLE_CYCLES > (1 << CNT_W) ||
        RETRY_CYCLES > (1 << CNT_W)) begin : g_bad_fit
      $error("rail_sequencer: cycle count exceeds CNT_W");
    end
  endgenerate

  logic [2:0]           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic [NUM_RAILS-1:0] en_q, en_d;
  logic [3:0]           fr_q, fr_d;

  logic [NUM_RAILS-1:0] lt_q, le_q, sel_q;
  logic [NUM_RAILS-1:0] lt_d, le_d;
  logic [NUM_RAILS-1:0] chk_mask, bad_mask;
  logic                 bad_any;
  logic [3:0]           bad_idx;
  logic                 pg_cur;

  // Rail masks relative to the current index.
  always_comb begin : dec_idx_q
    lt_q  = '0;
    le_q  = '0;
    sel_q = '0;
    for (int k = 0; k < NUM_RAILS; k++) begin
      lt_q[k]  = (4'(k) <  idx_q);
      le_q[k]  = (4'(k) <= idx_q);
      sel_q[k] = (4'(k) == idx_q);
    end
  end

  // Same masks for the index being loaded.
  always_comb begin : dec_idx_d
    lt_d = '0;
    le_d = '0;
    for (int k = 0; k < NUM_RAILS; k++) begin
      lt_d[k] = (4'(k) <  idx_d);
      le_d[k] = (4'(k) <= idx_d);
    end
  end

  assign pg_cur = |(pg & sel_q);

  // Rails that must already be good in this state.
  always_comb begin : chk_sel
    chk_mask = '0;
    unique case (1'b1)
      (state_q == S_RAMP):   chk_mask = lt_q;
      (state_q == S_SETTLE): chk_mask = le_q;
      (state_q == S_ON):     chk_mask = '1;
      default:               chk_mask = '0;
    endcase
  end

  assign bad_mask = chk_mask & ~pg;

  // Descending scan leaves the lowest failing rail.
  always_comb begin : bad_scan
    bad_any = 1'b0;
    bad_idx = '0;
    for (int k = NUM_RAILS - 1; k >= 0; k--) begin
      if (bad_mask[k]) begin
        bad_any = 1'b1;
        bad_idx = 4'(k);
      end
    end
  end

  // Saturating: holds at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q
                            : cnt_q + CNT_W'(1);

  always_comb begin : fsm
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fr_d    = fr_q;
    case (state_q)
      S_OFF: begin
        idx_d = '0;
        cnt_d = '0;
        fr_d  = '0;
        if (enable) begin
          state_d = S_RAMP;
        end
      end
      S_RAMP: begin
        cnt_d = cnt_inc;
        if (bad_any) begin
          state_d = S_FAULT;
          fr_d    = bad_idx;
          cnt_d   = '0;
        end else if (!pg_cur &&
                     cnt_q == TMO_LAST) begin
          state_d = S_FAULT;
          fr_d    = idx_q;
          cnt_d   = '0;
        end else if (!enable) begin
          state_d = S_SHUTDOWN;
          cnt_d   = '0;
        end else if (pg_cur) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_inc;
        if (bad_any) begin
          state_d = S_FAULT;
          fr_d    = bad_idx;
          cnt_d   = '0;
        end else if (!enable) begin
          state_d = S_SHUTDOWN;
          cnt_d   = '0;
        end else if (cnt_q == SET_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_ON;
          end else begin
            state_d = S_RAMP;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      S_ON: begin
        cnt_d = '0;
        if (bad_any) begin
          state_d = S_FAULT;
          fr_d    = bad_idx;
        end else if (!enable) begin
          state_d = S_SHUTDOWN;
          idx_d   = LAST_IDX;
        end
      end
      // pg and enable are ignored until OFF.
      S_SHUTDOWN: begin
        cnt_d = cnt_inc;
        if (cnt_q == SET_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd0) begin
            state_d = S_OFF;
          end else begin
            idx_d = idx_q - 4'd1;
          end
        end
      end
      S_FAULT: begin
`ifdef RAIL_SEQ_AUTO_RETRY_EN
        cnt_d = cnt_inc;
        if (!enable ||
            cnt_q == RTY_LAST) begin
          state_d = S_OFF;
          idx_d   = '0;
          cnt_d   = '0;
          fr_d    = '0;
        end
`else
        if (!enable) begin
          state_d = S_OFF;
          idx_d   = '0;
          cnt_d   = '0;
          fr_d    = '0;
        end
`endif
      end
      default: begin
        state_d = S_OFF;
        idx_d   = '0;
        cnt_d   = '0;
        fr_d    = '0;
      end
    endcase
  end

  // Enables follow the next state so they change on the
  // same edge as the transition, with no path from pg.
  always_comb begin : en_sel
    en_d = '0;
    unique case (1'b1)
      (state_d == S_RAMP):     en_d = le_d;
      (state_d == S_SETTLE):   en_d = le_d;
      (state_d == S_ON):       en_d = '1;
      (state_d == S_SHUTDOWN): en_d = lt_d;
      default:                 en_d = '0;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      fr_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      fr_q    <= fr_d;
    end
  end

  assign en         = en_q;
  assign state      = state_q;
  assign all_good   = (state_q == S_ON);
  assign fault      = (state_q == S_FAULT);
  assign fault_rail = fr_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// tb_rail_sequencer: scoreboard bench for rail_sequencer
// (4 rails, settle 4, timeout 20, retry 10).
`timescale 1ns/1ps

module tb_rail_sequencer;

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic [3:0] en;
    logic [3:0] fr;
    int         dly;
  } exp_t;

  logic       sysclk    = 1'b0;
  logic       reset_INV = 1'b1;
  logic       enable    = 1'b0;
  logic [3:0] pg;
  logic [3:0] en;
  logic [3:0] fault_rail;
  logic       all_good;
  logic       fault;
  logic [2:0] state;
  logic [3:0] mask = '0;
  logic [3:0] d0 = '0;
  logic [3:0] d1 = '0;
  logic [3:0] d2 = '0;

  exp_t        q[$];
  int          npass   = 0;
  int          nchk    = 0;
  int          cyc     = 0;
  int          last    = 0;
  int          tmo_req = 0;
  int          tmo_ack = 0;
  int          tmo_left = 0;
  bit          mon_en  = 1'b0;
  logic [12:0] prev    = '1;

  rail_sequencer #(
    .NUM_RAILS      (4),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (20),
    .SETTLE_CYCLES  (4),
    .RETRY_CYCLES   (10)
  ) dut (
    .sysclk     (sysclk),
    .reset_INV  (reset_INV),
    .enable     (enable),
    .pg         (pg),
    .en         (en),
    .all_good   (all_good),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state      (state)
  );

  always #5 sysclk = ~sysclk;

  // Rail model: pg follows en three cycles later.
  always @(negedge sysclk) begin
    d0 <= en;
    d1 <= d0;
    d2 <= d1;
  end
  assign pg = d2 & ~mask;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] obs();
    return {state, en, all_good, fault, fault_rail};
  endfunction

  function automatic logic [12:0] pack(exp_t e);
    return {e.st, e.en, e.st == 3'd3,
            e.st == 3'd5, e.fr};
  endfunction

  task automatic cmp(exp_t e, logic [12:0] o);
    logic [12:0] w;
    w = pack(e);
    nchk++;
    if (o !== w)
      $display("FAIL %s: got st=%0d en=%b ag=%b flt=%b fr=%0d, want st=%0d en=%b ag=%b flt=%b fr=%0d",
               e.nm, o[12:10], o[9:6], o[5], o[4], o[3:0],
               w[12:10], w[9:6], w[5], w[4], w[3:0]);
    else
      npass++;
  endtask

  // Monitor: every change of the observed outputs pops
  // one expectation; reset edges are checked 1ns later.
  always begin
    exp_t        e;
    logic [12:0] o;
    @(negedge sysclk or negedge reset_INV);
    if (mon_en && !reset_INV) begin
      #1;
      o = obs();
      if (q.size() == 0) begin
        nchk++;
        $display("FAIL unexpected reset: got st=%0d en=%b, want none",
                 o[12:10], o[9:6]);
      end else begin
        e = q.pop_front();
        cmp(e, o);
      end
      prev = o;
    end else if (mon_en) begin
      cyc++;
      if (tmo_req != tmo_ack) begin
        nchk++;
        $display("FAIL drain: got %0d entries left, want 0",
                 tmo_left);
        tmo_ack = tmo_req;
      end
      o = obs();
      if (o !== prev) begin
        if (q.size() == 0) begin
          nchk++;
          $display("FAIL unexpected: got st=%0d en=%b fr=%0d, want no change",
                   o[12:10], o[9:6], o[3:0]);
        end else begin
          e = q.pop_front();
          cmp(e, o);
          if (e.dly >= 0) begin
            nchk++;
            if (cyc - last != e.dly)
              $display("FAIL %s timing: got %0d cycles, want %0d",
                       e.nm, cyc - last, e.dly);
            else
              npass++;
          end
        end
        last = cyc;
        prev = o;
      end
    end
  end

  task automatic push(string nm, logic [2:0] st,
                      logic [3:0] e, logic [3:0] fr,
                      int dly);
    exp_t x;
    x.nm  = nm;
    x.st  = st;
    x.en  = e;
    x.fr  = fr;
    x.dly = dly;
    q.push_back(x);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge sysclk);
      #1;
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge sysclk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      tmo_left = q.size();
      q.delete();
      tmo_req++;
    end
  endtask

  // pg rises 3 cycles after each en, dwell is 4 cycles.
  task automatic push_ramp(int upto);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < upto; i++) begin
      m[i] = 1'b1;
      push($sformatf("ramp r%0d", i), 3'd1, m, 4'd0,
           (i == 0) ? -1 : 4);
      push($sformatf("settle r%0d", i), 3'd2, m, 4'd0, 3);
    end
  endtask

  task automatic push_pu();
    push_ramp(4);
    push("on", 3'd3, 4'b1111, 4'd0, 4);
  endtask

  initial begin
    reset_INV = 1'b0;
    tick(3);
    reset_INV = 1'b1;
    push("reset", 3'd0, 4'b0000, 4'd0, -1);
    mon_en = 1'b1;
    drain(10);

    // Full power-up.
    push_pu();
    enable = 1'b1;
    drain(200);

    // Full power-down from ON.
    push("dn 0111", 3'd4, 4'b0111, 4'd0, -1);
    push("dn 0011", 3'd4, 4'b0011, 4'd0, 4);
    push("dn 0001", 3'd4, 4'b0001, 4'd0, 4);
    push("dn 0000", 3'd4, 4'b0000, 4'd0, 4);
    push("dn off",  3'd0, 4'b0000, 4'd0, 4);
    enable = 1'b0;
    drain(100);
    tick(5);

    // Rail 2 never good: timeout 20 cycles after en[2].
    mask = 4'b0100;
    push_ramp(2);
    push("tmo r2", 3'd1, 4'b0111, 4'd0, 4);
    push("tmo flt", 3'd5, 4'b0000, 4'd2, 20);
    enable = 1'b1;
    drain(200);
`ifdef RAIL_SEQ_AUTO_RETRY_EN
    push("rty off",  3'd0, 4'b0000, 4'd0, 10);
    push("rty ramp", 3'd1, 4'b0001, 4'd0, 1);
    drain(50);
    push("rty sd",  3'd4, 4'b0000, 4'd0, -1);
    push("rty end", 3'd0, 4'b0000, 4'd0, 4);
    enable = 1'b0;
    drain(50);
`else
    tick(15);
    push("tmo clr", 3'd0, 4'b0000, 4'd0, -1);
    enable = 1'b0;
    drain(50);
`endif
    mask = 4'b0000;
    tick(5);

    // pg[1],pg[2] drop with enable in ON: lowest rail wins.
    push_pu();
    enable = 1'b1;
    drain(200);
    push("on flt", 3'd5, 4'b0000, 4'd1, -1);
    push("on clr", 3'd0, 4'b0000, 4'd0, 1);
    mask   = 4'b0110;
    enable = 1'b0;
    drain(50);
    mask = 4'b0000;
    tick(5);

    // Asynchronous reset in the middle of power-down.
    push_pu();
    enable = 1'b1;
    drain(200);
    push("ar 0111", 3'd4, 4'b0111, 4'd0, -1);
    push("ar 0011", 3'd4, 4'b0011, 4'd0, 4);
    enable = 1'b0;
    drain(50);
    push("async rst", 3'd0, 4'b0000, 4'd0, -1);
    #1;
    reset_INV = 1'b0;
    #2;
    reset_INV = 1'b1;
    drain(10);
    tick(5);

    // enable drop mid-ramp; re-raise ignored until OFF.
    push_ramp(1);
    push("mr r1", 3'd1, 4'b0011, 4'd0, 4);
    enable = 1'b1;
    drain(100);
    push("mr sd1", 3'd4, 4'b0001, 4'd0, -1);
    enable = 1'b0;
    drain(50);
    push("mr sd0", 3'd4, 4'b0000, 4'd0, 4);
    push("mr off", 3'd0, 4'b0000, 4'd0, 4);
    push("mr re",  3'd1, 4'b0001, 4'd0, 1);
    enable = 1'b1;
    drain(50);
    push("mr sd",  3'd4, 4'b0000, 4'd0, -1);
    push("mr end", 3'd0, 4'b0000, 4'd0, 4);
    enable = 1'b0;
    drain(50);

    tick(3);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
